// File: rtl/sipo_rx.sv
// sipo_rx: LSB-first serial-to-parallel receiver with a valid/ready holding register and overrun flag; define SIPO_PARITY_EN to add a trailing even-parity bit
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_en,
    input  logic             clr,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           st;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, po_q, po_d, word;
    logic             po_valid_q, po_valid_d, overrun_q, overrun_d;
    logic             accept, last, load, data_bit;

    // Frame phase is implied by the bit counter alone
    always_comb begin
        st = (cnt_q != '0) ? SHIFT : IDLE;
`ifdef SIPO_PARITY_EN
        if (cnt_q == CW'(WIDTH)) st = PARITY;
`endif
    end

    // Next-state for counter, shifter, holding register and overrun flag
    always_comb begin
        accept     = si_en && !clr;
        data_bit   = (st != PARITY);
        last       = accept && (cnt_q == CW'(FRAME - 1));
        word       = data_bit ? {si, sh_q[WIDTH-1:1]} : sh_q;
        load       = last && (!po_valid_q || po_ready);
        cnt_d      = clr ? '0 : !accept ? cnt_q : last ? '0 : cnt_q + 1'b1;
        sh_d       = clr ? '0 : (accept && data_bit) ? word : sh_q;
        po_d       = load ? word : po_q;
        po_valid_d = clr ? 1'b0 : load ? 1'b1 : (po_valid_q && po_ready) ? 1'b0 : po_valid_q;
        overrun_d  = clr ? 1'b0 : (last && po_valid_q && !po_ready) ? 1'b1 : overrun_q;
    end

    // State registers; reset drops any partial frame and the held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Parity verdict travels with the word it belongs to
    always_comb begin
        parity_err_d = clr ? 1'b0 : load ? (^sh_q ^ si) : parity_err_q;
    end

    // Parity result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err_q <= 1'b0;
        else     parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign overrun  = overrun_q;
    assign busy     = (st != IDLE);
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in, parallel-out receiver that reassembles LSB-first bit streams into WIDTH-bit words. It sits directly downstream of the 4-bit PISO serializer and consumes its `so` stream one bit per qualified clock. It presents each completed word through a single-entry valid/ready holding register and flags words dropped under backpressure.

## Interface
Parameters:
- WIDTH, 4, data bits per frame (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- si  in  1  serial data bit, LSB of word first
- si_en  in  1  bit qualifier; `si` sampled only when high
- clr  in  1  synchronous abort/clear; priority over `si_en`
- po  out  WIDTH  assembled word in holding register
- po_valid  out  1  `po` holds an unconsumed word
- po_ready  in  1  consumer accepts `po` when high with `po_valid`
- busy  out  1  frame in progress (bit count ≠ 0)
- overrun  out  1  sticky; a completed word was dropped
- parity_err  out  1  parity result for the word in `po` (0 when parity compiled out)

## Operation
- Shift register `sh[WIDTH-1:0]`; on accepted bit: `sh <= {si, sh[WIDTH-1:1]}`. After WIDTH bits, `sh[0]` = first bit received.
- Bit counter `cnt`, width clog2(FRAME). FRAME = WIDTH, or WIDTH+1 with parity. Counts 0..FRAME-1, then wraps to 0 on the last bit.
- States, derived from `cnt`:
  - IDLE: cnt=0
  - SHIFT: 0<cnt<WIDTH
  - PARITY: cnt=WIDTH, parity build only
- Completion: the accepted bit with cnt=FRAME-1 ends the frame. The assembled word (including the current bit when it is a data bit) is offered to the holding register on that same edge.
- Holding register transfer on completion:
  - If `po_valid`=0, or `po_valid`=1 and `po_ready`=1 in that cycle: load `po`, set `po_valid`=1.
  - If `po_valid`=1 and `po_ready`=0: the new word is discarded, `po` is unchanged, and `overrun` is set to 1.
- Consume without completion: `po_valid` && `po_ready` clears `po_valid` at the next edge. `po` retains its last value.
- `overrun` stays set until `clr` or `rst`.
- `clr` (synchronous): cnt←0, sh←0, po_valid←0, overrun←0, parity_err←0. `po` data is unchanged. Any `si_en` in the same cycle is ignored.
- `rst` (asynchronous): cnt, sh, po, po_valid, overrun and parity_err all go to 0 immediately. A partial frame is lost. `busy`=0.
- `si_en`=0 cycles insert gaps freely; state is held.

## Timing
- Reset values: po=0, po_valid=0, busy=0, overrun=0, parity_err=0.
- Latency: `po`/`po_valid` update on the same rising edge that samples the final bit of the frame and are visible for the following cycle.
- Minimum frame duration: FRAME cycles. Back-to-back frames with continuous `si_en` are supported with no idle cycle.
- With `po_ready` held high, `po_valid` is a one-cycle pulse per word.
- `busy` is combinational from `cnt`: high from the edge after the first accepted bit until the completion edge.
- A registered `so` upstream output is sampled directly; no extra input synchronization is required (same clock domain).

## Configuration
- SIPO_PARITY_EN defined:
  - FRAME = WIDTH+1; the final bit is an even-parity bit.
  - `parity_err` = XOR of the WIDTH data bits XOR the parity bit.
  - `parity_err` is loaded together with `po`, held with it, and is meaningful only while `po_valid`=1.
- SIPO_PARITY_EN undefined:
  - FRAME = WIDTH; no parity state.
  - `parity_err` is tied 0.

## Test plan
- Basic (WIDTH=4, po_ready=1, si_en=1): bits 1,0,1,1 → `po`=4'b1101 and `po_valid`=1 for exactly one cycle after the 4th edge. `busy` is high during bits 2–4.
- Gapped input: same bits with si_en=0 for 3 cycles between each → `po`=4'b1101 once. `busy` stays high across the gaps and `po_valid` does not assert early.
- Backpressure: po_ready=0; send 1101, then 0110 (bits 0,1,1,0) → `po` stays 4'b1101, `po_valid`=1, `overrun`=1. Pulse `clr` → po_valid=0, overrun=0.
- Simultaneous consume/complete: `po`=1101 pending, po_ready=1 on the edge completing 0110 → `po`=4'b0110, po_valid=1, overrun=0.
- Reset mid-frame: 2 bits accepted, then rst pulse (asynchronous, between edges) → all outputs 0 immediately. A following 1,0,1,1 frame yields `po`=4'b1101.
- Parity (SIPO_PARITY_EN): bits 1,0,1,1 then p=1 → `po`=1101, parity_err=0. Bits 1,0,1,1 then p=0 → parity_err=1.
